// File: rtl/adc_framer_if.sv
// FIFO-side bus of the ADC framer: data word, write strobe and almost-full back-pressure.
interface adc_framer_if #(
  parameter int unsigned W = 40
) ();
  logic [W-1:0] odata;
  logic         wren;
  logic         afull;

  modport master (output odata, output wren, input afull);
  modport slave  (input odata, input wren, output afull);
endinterface

// File: rtl/adc_framer.sv
// ADC sample framer: decimates (drop or peak-hold), packs SPW samples per word,
// prefixes each frame with a header and drops whole words under FIFO back-pressure.
module adc_framer #(
  parameter int unsigned SW        = 10,
  parameter int unsigned SPW       = 4,
  parameter int unsigned DECIM_W   = 8,
  parameter int unsigned FRAME_LEN = 256,
  parameter logic [7:0]  MARKER    = 8'hA5
) (
  input  logic               clk50,
  input  logic               reset_n,
  input  logic               en,
  input  logic               mode,
  input  logic [DECIM_W-1:0] decim,
  input  logic [SW-1:0]      adpin,
  input  logic               adcovr,
  adc_framer_if.master       fifo,
  output logic [15:0]        seq,
  output logic               busy
);

  localparam int unsigned W   = SW * SPW;
  localparam int unsigned DRW = W - 25;
  localparam int unsigned LW  = (SPW > 1) ? $clog2(SPW) : 1;
  localparam int unsigned WCW = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t             r_state;
  logic [SW-1:0]      r_adpin;
  logic               r_adcovr;
  logic               r_vld;
  logic [DECIM_W-1:0] r_decim;
  logic               r_mode;
  logic [DECIM_W-1:0] r_dcnt;
  logic [SW-1:0]      r_max;
  logic [LW-1:0]      r_lane;
  logic [W-1:0]       r_word;
  logic [WCW-1:0]     r_wcnt;
  logic               r_ovr;
  logic [DRW-1:0]     r_drop;
  logic [15:0]        r_seq;
  logic [W-1:0]       r_odata;
  logic               r_wren;

  logic               w_consume;
  logic               w_win_start;
  logic               w_win_end;
  logic [SW-1:0]      w_peak;
  logic               w_keep;
  logic [SW-1:0]      w_kept_val;
  logic               w_full;
  logic [W-1:0]       w_word;
  logic [W-1:0]       w_hdr;
  logic [DRW-1:0]     w_drop_inc;

  // Window tracking and lane insertion for the sample currently in the input register.
  always_comb begin
    w_consume   = (r_state == DATA) && r_vld;
    w_win_start = (r_dcnt == '0);
    w_win_end   = (r_dcnt == r_decim);
    w_peak      = w_win_start ? r_adpin : ((r_adpin > r_max) ? r_adpin : r_max);
    w_keep      = w_consume && (r_mode ? w_win_end : w_win_start);
    w_kept_val  = r_mode ? w_peak : r_adpin;
    w_full      = w_keep && (r_lane == LW'(SPW - 1));
    w_word      = r_word;
    w_word[SW * 32'(r_lane) +: SW] = w_kept_val;
    w_hdr       = {MARKER, r_seq, r_ovr, r_drop};
    w_drop_inc  = (r_drop == '1) ? r_drop : r_drop + DRW'(1);
  end

  // Input stage; r_vld marks samples that arrived while capturing data.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_adpin  <= '0;
      r_adcovr <= 1'b0;
      r_vld    <= 1'b0;
    end else begin
      r_adpin  <= adpin;
      r_adcovr <= adcovr;
      r_vld    <= (r_state == DATA);
    end
  end

  // Framing FSM with registered FIFO outputs and frame statistics.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_decim <= '0;
      r_mode  <= 1'b0;
      r_dcnt  <= '0;
      r_max   <= '0;
      r_lane  <= '0;
      r_word  <= '0;
      r_wcnt  <= '0;
      r_ovr   <= 1'b0;
      r_drop  <= '0;
      r_seq   <= '0;
      r_odata <= '0;
      r_wren  <= 1'b0;
    end else begin
      r_wren <= 1'b0;
      case (r_state)
        IDLE: begin
          if (en) begin
            r_state <= HDR;
            r_decim <= decim;
            r_mode  <= mode;
          end
        end
        HDR: begin
          if (!en) begin
            r_state <= IDLE;
          end else if (!fifo.afull) begin
            r_odata <= w_hdr;
            r_wren  <= 1'b1;
            r_ovr   <= 1'b0;
            r_drop  <= '0;
            r_decim <= decim;
            r_mode  <= mode;
            r_dcnt  <= '0;
            r_lane  <= '0;
            r_word  <= '0;
            r_wcnt  <= '0;
            r_state <= DATA;
          end
        end
        DATA: begin
          if (!en) begin
            r_state <= IDLE;
          end else if (w_consume) begin
            r_dcnt <= w_win_end ? '0 : r_dcnt + DECIM_W'(1);
            r_max  <= w_peak;
            if (r_adcovr) begin
              r_ovr <= 1'b1;
            end
            if (w_full) begin
              if (!fifo.afull) begin
                r_odata <= w_word;
                r_wren  <= 1'b1;
              end else begin
                r_drop <= w_drop_inc;
              end
              r_lane <= '0;
              r_word <= '0;
              if (r_wcnt == WCW'(FRAME_LEN - 1)) begin
                r_wcnt  <= '0;
                r_seq   <= r_seq + 16'd1;
                r_state <= HDR;
              end else begin
                r_wcnt <= r_wcnt + WCW'(1);
              end
            end else if (w_keep) begin
              r_word <= w_word;
              r_lane <= r_lane + LW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fifo.odata = r_odata;
  assign fifo.wren  = r_wren;
  assign seq        = r_seq;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_adc_framer.sv
// Directed bench for adc_framer: SW=10, SPW=4, FRAME_LEN=4 (W=40).
module tb_adc_framer;

  logic       clk50;
  logic       reset_n;
  logic       en;
  logic       mode;
  logic [7:0] decim;
  logic [9:0] adpin;
  logic       adcovr;
  logic [15:0] seq;
  logic       busy;

  adc_framer_if #(.W(40)) fifo ();

  adc_framer #(
    .SW(10), .SPW(4), .DECIM_W(8), .FRAME_LEN(4), .MARKER(8'hA5)
  ) dut (
    .clk50  (clk50),
    .reset_n(reset_n),
    .en     (en),
    .mode   (mode),
    .decim  (decim),
    .adpin  (adpin),
    .adcovr (adcovr),
    .fifo   (fifo),
    .seq    (seq),
    .busy   (busy)
  );

  initial clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [39:0] q[$];
  int unsigned ramp;
  bit          ramp_en;
  int unsigned ovr_at;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] pack4(input int a, input int b, input int c, input int d);
    return {10'(d), 10'(c), 10'(b), 10'(a)};
  endfunction

  function automatic logic [39:0] hdr(input int s, input bit ovr, input int drops);
    return {8'hA5, 16'(s), ovr, 15'(drops)};
  endfunction

  // One clock: capture any written word, then drive the next ramp sample.
  task automatic step();
    @(posedge clk50);
    #1;
    if (fifo.wren) q.push_back(fifo.odata);
    if (ramp_en) begin
      adpin  = 10'(ramp);
      adcovr = (ramp == ovr_at);
      ramp++;
    end else begin
      adcovr = 1'b0;
    end
  endtask

  task automatic wait_words(input int n);
    int b = 0;
    while (q.size() < n && b < 400) begin
      step();
      b++;
    end
    if (q.size() < n) check("wait_words_timeout", 64'(q.size()), 64'(n));
  endtask

  // IDLE->HDR, then header written; ramp value 1 lands in the first DATA cycle.
  task automatic start_frame();
    en      = 1'b1;
    ramp_en = 1'b0;
    adpin   = '0;
    ramp    = 1;
    step();
    ramp_en = 1'b1;
    step();
  endtask

  task automatic abort();
    en      = 1'b0;
    ramp_en = 1'b0;
    step();
  endtask

  initial begin
    reset_n    = 1'b0;
    en         = 1'b0;
    mode       = 1'b0;
    decim      = '0;
    adpin      = '0;
    adcovr     = 1'b0;
    fifo.afull = 1'b0;
    ramp       = 1;
    ramp_en    = 1'b0;
    ovr_at     = 0;

    // Reset state
    #3;
    check("rst_wren", 64'(fifo.wren), 64'd0);
    check("rst_odata", 64'(fifo.odata), 64'd0);
    check("rst_seq", 64'(seq), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk50);
    reset_n = 1'b1;

    // 1: raw packing
    q.delete();
    en = 1'b1;
    step();
    check("t1_busy_hdr", 64'(busy), 64'd1);
    ramp_en = 1'b1;
    step();
    wait_words(6);
    if (q.size() >= 6) begin
      check("t1_hdr0", 64'(q[0]), 64'(40'hA5_0000_0000));
      check("t1_w0", 64'(q[1]), 64'(pack4(1, 2, 3, 4)));
      check("t1_w1", 64'(q[2]), 64'(pack4(5, 6, 7, 8)));
      check("t1_w2", 64'(q[3]), 64'(pack4(9, 10, 11, 12)));
      check("t1_w3", 64'(q[4]), 64'(pack4(13, 14, 15, 16)));
      check("t1_hdr1", 64'(q[5]), 64'(40'hA5_0001_0000));
    end
    check("t1_seq", 64'(seq), 64'd1);
    abort();
    check("t1_abort_busy", 64'(busy), 64'd0);

    // 2: decimation by drop, then peak-hold
    decim = 8'd2;
    mode  = 1'b0;
    q.delete();
    start_frame();
    wait_words(2);
    if (q.size() >= 2) begin
      check("t2_hdr", 64'(q[0]), 64'(hdr(1, 1'b0, 0)));
      check("t2_drop_w0", 64'(q[1]), 64'(pack4(1, 4, 7, 10)));
    end
    abort();
    mode = 1'b1;
    q.delete();
    start_frame();
    wait_words(2);
    if (q.size() >= 2) check("t2_peak_w0", 64'(q[1]), 64'(pack4(3, 6, 9, 12)));
    abort();

    // 3: back-pressure on data words 2 and 3, then header held by afull
    decim = 8'd0;
    mode  = 1'b0;
    q.delete();
    start_frame();
    for (int c = 1; c <= 17; c++) begin
      fifo.afull = (c >= 9 && c <= 13);
      step();
    end
    check("t3_data_wrens", 64'(q.size()), 64'd3);
    if (q.size() >= 3) check("t3_w3", 64'(q[2]), 64'(pack4(13, 14, 15, 16)));
    fifo.afull = 1'b1;
    for (int c = 0; c < 3; c++) step();
    check("t3_hdr_held", 64'(q.size()), 64'd3);
    check("t3_busy_held", 64'(busy), 64'd1);
    fifo.afull = 1'b0;
    step();
    check("t3_hdr_count", 64'(q.size()), 64'd4);
    if (q.size() >= 4) begin
      check("t3_hdr_drop", 64'(q[3][14:0]), 64'd2);
      check("t3_hdr_ovr", 64'(q[3][15]), 64'd0);
      check("t3_hdr_seq", 64'(q[3][31:16]), 64'd2);
    end
    abort();

    // 4: overrange on a non-kept sample (decim=3, sample 3 sits at dcnt=2)
    decim  = 8'd3;
    ovr_at = 3;
    q.delete();
    start_frame();
    wait_words(6);
    ovr_at = 0;
    if (q.size() >= 6) begin
      check("t4_hdr_f0", 64'(q[0]), 64'(hdr(2, 1'b0, 0)));
      check("t4_w0", 64'(q[1]), 64'(pack4(1, 5, 9, 13)));
      check("t4_hdr_f1", 64'(q[5]), 64'(hdr(3, 1'b1, 0)));
    end
    wait_words(11);
    if (q.size() >= 11) check("t4_hdr_f2", 64'(q[10]), 64'(hdr(4, 1'b0, 0)));
    abort();

    // 5: abort with two lanes filled, after one dropped word
    decim = 8'd0;
    q.delete();
    start_frame();
    for (int c = 1; c <= 7; c++) begin
      fifo.afull = (c == 5);
      step();
    end
    fifo.afull = 1'b0;
    check("t5_only_hdr", 64'(q.size()), 64'd1);
    abort();
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_wren", 64'(fifo.wren), 64'd0);
    for (int c = 0; c < 8; c++) step();
    check("t5_no_wren", 64'(q.size()), 64'd1);
    start_frame();
    check("t5_rehdr_count", 64'(q.size()), 64'd2);
    if (q.size() >= 2) check("t5_rehdr", 64'(q[1]), 64'(hdr(4, 1'b0, 1)));

    // 6: async reset between edges while a data word is on the bus
    for (int c = 1; c <= 5; c++) step();
    check("t6_pre_wren", 64'(fifo.wren), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_wren", 64'(fifo.wren), 64'd0);
    check("t6_odata", 64'(fifo.odata), 64'd0);
    check("t6_seq", 64'(seq), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    ramp_en = 1'b0;
    @(negedge clk50);
    reset_n = 1'b1;
    q.delete();
    wait_words(1);
    if (q.size() >= 1) check("t6_hdr", 64'(q[0]), 64'(40'hA5_0000_0000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
